// File: rtl/ncl_q_pkg.sv
// Shared quaternary NCL encodings, helpers and the serial adder state type.
package ncl_q_pkg;

  localparam logic [3:0] Q0    = 4'b0001;
  localparam logic [3:0] Q1    = 4'b0010;
  localparam logic [3:0] Q2    = 4'b0100;
  localparam logic [3:0] Q3    = 4'b1000;
  localparam logic [3:0] QNULL = 4'b0000;

  localparam logic [1:0] R0    = 2'b01;
  localparam logic [1:0] R1    = 2'b10;
  localparam logic [1:0] RNULL = 2'b00;

  typedef enum logic [1:0] {IDLE, CALC, PRESENT, DRAIN} state_t;

  // True when exactly one rail of a quaternary digit is high.
  function automatic logic q_valid(input logic [3:0] q);
    case (q)
      Q0, Q1, Q2, Q3: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic q_is_null(input logic [3:0] q);
    return (q == QNULL);
  endfunction

  // Digit value of a one-hot digit; anything that is not one-hot reads as 0.
  function automatic logic [1:0] q_to_int(input logic [3:0] q);
    case (q)
      Q1:      return 2'd1;
      Q2:      return 2'd2;
      Q3:      return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] int_to_q(input logic [1:0] v);
    case (v)
      2'd0:    return Q0;
      2'd1:    return Q1;
      2'd2:    return Q2;
      default: return Q3;
    endcase
  endfunction

endpackage

// File: rtl/qadd_digit.sv
// One quaternary digit cell; in subtract mode both carry rails carry a borrow,
// so the cell can be chained serially without any conversion between digits.
module qadd_digit
  import ncl_q_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [1:0] c_i,
  input  logic       sub_i,
  output logic [3:0] s_o,
  output logic [1:0] cout_o
);

  logic [1:0] aVal;
  logic [1:0] bVal;
  logic       cEff;
  logic [2:0] total;

  // Add a + b (or a + complement of b) + effective carry and re-encode one-hot.
  always_comb begin
    aVal   = q_to_int(a_i);
    bVal   = sub_i ? (2'd3 - q_to_int(b_i)) : q_to_int(b_i);
    cEff   = sub_i ? c_i[0] : c_i[1];
    total  = {1'b0, aVal} + {1'b0, bVal} + {2'b00, cEff};
    s_o    = int_to_q(total[1:0]);
    cout_o = (total[2] ^ sub_i) ? R1 : R0;
  end

endmodule

// File: rtl/ncl_qadd_serial.sv
// Digit-serial quaternary NCL adder/subtractor with DATA/NULL completion handshakes.
module ncl_qadd_serial
  import ncl_q_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CNTW   = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                init,
  input  logic [4*DIGITS-1:0] AQ,
  input  logic [4*DIGITS-1:0] BQ,
  input  logic [1:0]          carryin,
  input  logic                sub,
  output logic                ABCOMP,
  output logic [4*DIGITS-1:0] sumQ,
  output logic [1:0]          carryout,
  input  logic                sumCOMP,
  input  logic                carryCOMP,
  output logic                sumcarryCOMP,
  output logic                code_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [CNTW-1:0] LAST = CNTW'(DIGITS);

  state_t          state_q;
  logic [W-1:0]    aOp_q;
  logic [W-1:0]    bOp_q;
  logic [W-1:0]    result_q;
  logic [W-1:0]    sumOut_q;
  logic [1:0]      carry_q;
  logic [1:0]      carryOut_q;
  logic            subMode_q;
  logic            abComp_q;
  logic            scComp_q;
  logic            codeErr_q;
  logic [CNTW-1:0] cnt_q;

  logic            inData;
  logic            inNull;
  logic            multiRail;
  logic [3:0]      curA;
  logic [3:0]      curB;
  logic [3:0]      digitSum;
  logic [1:0]      digitCarry;

  // Classify the input wavefront: complete DATA, complete NULL, or any multi-rail code.
  always_comb begin
    inData    = 1'b1;
    inNull    = 1'b1;
    multiRail = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!q_valid(AQ[4*k +: 4])) inData = 1'b0;
      if (!q_valid(BQ[4*k +: 4])) inData = 1'b0;
      if (!q_is_null(AQ[4*k +: 4])) inNull = 1'b0;
      if (!q_is_null(BQ[4*k +: 4])) inNull = 1'b0;
      if (!q_valid(AQ[4*k +: 4]) && !q_is_null(AQ[4*k +: 4])) multiRail = 1'b1;
      if (!q_valid(BQ[4*k +: 4]) && !q_is_null(BQ[4*k +: 4])) multiRail = 1'b1;
    end
    if (carryin != R0 && carryin != R1) inData = 1'b0;
    if (carryin != RNULL) inNull = 1'b0;
    if (carryin == 2'b11) multiRail = 1'b1;
  end

  // Select the latched operand digits the serial cell works on this cycle.
  always_comb begin
    curA = QNULL;
    curB = QNULL;
    for (int k = 0; k < DIGITS; k++) begin
      if (cnt_q == CNTW'(k)) begin
        curA = aOp_q[4*k +: 4];
        curB = bOp_q[4*k +: 4];
      end
    end
  end

  qadd_digit u_digit (
    .a_i    (curA),
    .b_i    (curB),
    .c_i    (carry_q),
    .sub_i  (subMode_q),
    .s_o    (digitSum),
    .cout_o (digitCarry)
  );

  // Control FSM with registered outputs: accept, compute one digit per cycle, present, drain.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q    <= IDLE;
      aOp_q      <= '0;
      bOp_q      <= '0;
      result_q   <= '0;
      sumOut_q   <= '0;
      carry_q    <= RNULL;
      carryOut_q <= RNULL;
      subMode_q  <= 1'b0;
      abComp_q   <= 1'b0;
      scComp_q   <= 1'b0;
      codeErr_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (multiRail) codeErr_q <= 1'b1;
      if (state_q != IDLE && inNull) abComp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!abComp_q && inData) begin
            aOp_q     <= AQ;
            bOp_q     <= BQ;
            carry_q   <= carryin;
            subMode_q <= sub;
            abComp_q  <= 1'b1;
            result_q  <= '0;
            cnt_q     <= '0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          if (cnt_q != LAST) begin
            for (int k = 0; k < DIGITS; k++) begin
              if (cnt_q == CNTW'(k)) result_q[4*k +: 4] <= digitSum;
            end
            carry_q <= digitCarry;
            cnt_q   <= cnt_q + 1'b1;
          end else begin
            sumOut_q   <= result_q;
            carryOut_q <= carry_q;
            scComp_q   <= 1'b1;
            state_q    <= PRESENT;
          end
        end
        PRESENT: begin
          if (sumCOMP && carryCOMP) begin
            sumOut_q   <= '0;
            carryOut_q <= RNULL;
            scComp_q   <= 1'b0;
            state_q    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!sumCOMP && !carryCOMP && !abComp_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ABCOMP       = abComp_q;
  assign sumQ         = sumOut_q;
  assign carryout     = carryOut_q;
  assign sumcarryCOMP = scComp_q;
  assign code_err     = codeErr_q;

endmodule

// File: tb/tb_ncl_qadd_serial.sv
// Self-checking bench for ncl_qadd_serial against an integer arithmetic model.
module tb_ncl_qadd_serial;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int MOD = 256;

  logic         clk = 1'b0;
  logic         init;
  logic [W-1:0] AQ;
  logic [W-1:0] BQ;
  logic [1:0]   carryin;
  logic         sub;
  logic         ABCOMP;
  logic [W-1:0] sumQ;
  logic [1:0]   carryout;
  logic         sumCOMP;
  logic         carryCOMP;
  logic         sumcarryCOMP;
  logic         code_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ncl_qadd_serial #(.DIGITS(D)) dut (
    .clk          (clk),
    .init         (init),
    .AQ           (AQ),
    .BQ           (BQ),
    .carryin      (carryin),
    .sub          (sub),
    .ABCOMP       (ABCOMP),
    .sumQ         (sumQ),
    .carryout     (carryout),
    .sumCOMP      (sumCOMP),
    .carryCOMP    (carryCOMP),
    .sumcarryCOMP (sumcarryCOMP),
    .code_err     (code_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-hot encoding of an integer, one quaternary digit per nibble.
  function automatic logic [W-1:0] enc(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) r[4*k +: 4] = 4'b0001 << ((v >> (2*k)) & 3);
    return r;
  endfunction

  // Reference: plain integer add, or subtract with borrow; returns encoded sum and carry/borrow.
  function automatic void model(input int a, input int b, input bit cin, input bit s,
                                output logic [W-1:0] sum, output logic [1:0] co);
    int r;
    if (!s) begin
      r   = a + b + int'(cin);
      sum = enc(r % MOD);
      co  = (r >= MOD) ? 2'b10 : 2'b01;
    end else begin
      r   = a - b - int'(cin);
      sum = enc((r + MOD) % MOD);
      co  = (r < 0) ? 2'b10 : 2'b01;
    end
  endfunction

  task automatic drive_data(input int a, input int b, input bit cin, input bit s);
    AQ      = enc(a);
    BQ      = enc(b);
    carryin = cin ? 2'b10 : 2'b01;
    sub     = s;
  endtask

  task automatic drive_null();
    AQ      = '0;
    BQ      = '0;
    carryin = 2'b00;
  endtask

  // Drive one operand set, wait for acceptance and for the presented result.
  task automatic run_op(input int a, input int b, input bit cin, input bit s,
                        output logic acc, output int lat,
                        output logic [W-1:0] sum, output logic [1:0] co);
    drive_data(a, b, cin, s);
    acc = 1'b0;
    lat = -1;
    for (int i = 0; i < 10 && !acc; i++) begin
      tick();
      if (ABCOMP === 1'b1) acc = 1'b1;
    end
    if (acc) begin
      lat = 0;
      while (sumcarryCOMP !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
    end
    sum = sumQ;
    co  = carryout;
  endtask

  // Return inputs to NULL, consume the result and let the adder drain back to idle.
  task automatic finish_op();
    drive_null();
    sub       = 1'b0;
    sumCOMP   = 1'b1;
    carryCOMP = 1'b1;
    tick();
    sumCOMP   = 1'b0;
    carryCOMP = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    init      = 1'b1;
    drive_null();
    sub       = 1'b0;
    sumCOMP   = 1'b0;
    carryCOMP = 1'b0;
    tick();
    tick();
    compared++; if (ABCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_abcomp: got %b expected 0", ABCOMP); end
    compared++; if (sumQ !== '0) begin mismatched++; $display("[TB] FAIL reset_sum: got %h expected 0", sumQ); end
    compared++; if (carryout !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_carry: got %b expected 00", carryout); end
    compared++; if (sumcarryCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sccomp: got %b expected 0", sumcarryCOMP); end
    compared++; if (code_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b expected 0", code_err); end
    init = 1'b0;
    tick();
  endtask

  task automatic test_add_example();
    logic acc; int lat; logic [W-1:0] s, es; logic [1:0] c, ec;
    model(27, 45, 1'b0, 1'b0, es, ec);
    run_op(27, 45, 1'b0, 1'b0, acc, lat, s, c);
    compared++; if (acc !== 1'b1) begin mismatched++; $display("[TB] FAIL add_accept: got %b expected 1", acc); end
    compared++; if (lat != 5) begin mismatched++; $display("[TB] FAIL add_latency: got %0d expected 5", lat); end
    compared++; if (s !== es) begin mismatched++; $display("[TB] FAIL add_sum: got %h expected %h", s, es); end
    compared++; if (c !== ec) begin mismatched++; $display("[TB] FAIL add_carry: got %b expected %b", c, ec); end
    finish_op();
  endtask

  task automatic test_overflow();
    logic acc; int lat; logic [W-1:0] s, es; logic [1:0] c, ec;
    model(255, 255, 1'b1, 1'b0, es, ec);
    run_op(255, 255, 1'b1, 1'b0, acc, lat, s, c);
    compared++; if (s !== es) begin mismatched++; $display("[TB] FAIL ovf_sum: got %h expected %h", s, es); end
    compared++; if (c !== ec) begin mismatched++; $display("[TB] FAIL ovf_carry: got %b expected %b", c, ec); end
    drive_null();
    sumCOMP   = 1'b1;
    carryCOMP = 1'b1;
    tick();
    compared++; if (sumQ !== '0) begin mismatched++; $display("[TB] FAIL ovf_null_sum: got %h expected 0", sumQ); end
    compared++; if (carryout !== 2'b00) begin mismatched++; $display("[TB] FAIL ovf_null_carry: got %b expected 00", carryout); end
    compared++; if (sumcarryCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_null_sccomp: got %b expected 0", sumcarryCOMP); end
    sumCOMP   = 1'b0;
    carryCOMP = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_subtract();
    int ta[2] = '{27, 45};
    int tb[2] = '{45, 27};
    logic acc; int lat; logic [W-1:0] s, es; logic [1:0] c, ec;
    for (int i = 0; i < 2; i++) begin
      model(ta[i], tb[i], 1'b0, 1'b1, es, ec);
      run_op(ta[i], tb[i], 1'b0, 1'b1, acc, lat, s, c);
      compared++; if (s !== es) begin mismatched++; $display("[TB] FAIL sub_sum[%0d]: got %h expected %h", i, s, es); end
      compared++; if (c !== ec) begin mismatched++; $display("[TB] FAIL sub_borrow[%0d]: got %b expected %b", i, c, ec); end
      finish_op();
    end
  endtask

  task automatic test_partial();
    AQ         = enc(27);
    AQ[15:12]  = 4'b0000;
    BQ         = enc(45);
    carryin    = 2'b01;
    sub        = 1'b0;
    repeat (4) tick();
    compared++; if (ABCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL partial_abcomp: got %b expected 0", ABCOMP); end
    compared++; if (code_err !== 1'b0) begin mismatched++; $display("[TB] FAIL partial_err: got %b expected 0", code_err); end
    drive_null();
    repeat (3) tick();
    compared++; if (sumcarryCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL premature_null_sccomp: got %b expected 0", sumcarryCOMP); end
    compared++; if (ABCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL premature_null_abcomp: got %b expected 0", ABCOMP); end
  endtask

  task automatic test_comp_stall();
    logic acc; int lat; logic [W-1:0] s, es; logic [1:0] c, ec;
    model(100, 200, 1'b1, 1'b0, es, ec);
    run_op(100, 200, 1'b1, 1'b0, acc, lat, s, c);
    sumCOMP = 1'b1;
    repeat (3) tick();
    compared++; if (sumQ !== es) begin mismatched++; $display("[TB] FAIL stall_hold_sum: got %h expected %h", sumQ, es); end
    compared++; if (sumcarryCOMP !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_hold_sccomp: got %b expected 1", sumcarryCOMP); end
    carryCOMP = 1'b1;
    tick();
    compared++; if (sumQ !== '0) begin mismatched++; $display("[TB] FAIL stall_release_sum: got %h expected 0", sumQ); end
    sumCOMP   = 1'b0;
    carryCOMP = 1'b0;
    repeat (8) tick();
    compared++; if (ABCOMP !== 1'b1) begin mismatched++; $display("[TB] FAIL held_data_abcomp: got %b expected 1", ABCOMP); end
    compared++; if (sumcarryCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL held_data_no_reaccept: got %b expected 0", sumcarryCOMP); end
    drive_null();
    repeat (3) tick();
    compared++; if (ABCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL held_data_abcomp_fall: got %b expected 0", ABCOMP); end
  endtask

  task automatic test_code_err();
    AQ        = enc(27);
    AQ[11:8]  = 4'b0110;
    BQ        = enc(45);
    carryin   = 2'b01;
    sub       = 1'b0;
    repeat (3) tick();
    compared++; if (code_err !== 1'b1) begin mismatched++; $display("[TB] FAIL err_set: got %b expected 1", code_err); end
    compared++; if (ABCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL err_no_accept: got %b expected 0", ABCOMP); end
    drive_null();
    tick();
    compared++; if (code_err !== 1'b1) begin mismatched++; $display("[TB] FAIL err_sticky: got %b expected 1", code_err); end
    init = 1'b1;
    tick();
    init = 1'b0;
    compared++; if (code_err !== 1'b0) begin mismatched++; $display("[TB] FAIL err_cleared: got %b expected 0", code_err); end
  endtask

  task automatic test_reset_mid();
    logic acc; int lat; logic [W-1:0] s, es; logic [1:0] c, ec;
    drive_data(200, 100, 1'b0, 1'b1);
    repeat (3) tick();
    init = 1'b1;
    drive_null();
    sub  = 1'b0;
    tick();
    init = 1'b0;
    compared++; if (ABCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_abcomp: got %b expected 0", ABCOMP); end
    compared++; if (sumQ !== '0) begin mismatched++; $display("[TB] FAIL midreset_sum: got %h expected 0", sumQ); end
    repeat (6) tick();
    compared++; if (sumcarryCOMP !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_no_partial: got %b expected 0", sumcarryCOMP); end
    model(200, 100, 1'b0, 1'b1, es, ec);
    run_op(200, 100, 1'b0, 1'b1, acc, lat, s, c);
    compared++; if (s !== es) begin mismatched++; $display("[TB] FAIL midreset_next_sum: got %h expected %h", s, es); end
    compared++; if (c !== ec) begin mismatched++; $display("[TB] FAIL midreset_next_carry: got %b expected %b", c, ec); end
    finish_op();
  endtask

  task automatic test_random();
    logic acc; int lat; logic [W-1:0] s, es; logic [1:0] c, ec;
    int a, b; bit cin, sm;
    for (int i = 0; i < 24; i++) begin
      a   = int'($urandom_range(MOD - 1));
      b   = int'($urandom_range(MOD - 1));
      cin = 1'($urandom_range(1));
      sm  = 1'($urandom_range(1));
      model(a, b, cin, sm, es, ec);
      run_op(a, b, cin, sm, acc, lat, s, c);
      compared++; if (lat != 5) begin mismatched++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected 5", i, lat); end
      compared++; if (s !== es) begin mismatched++; $display("[TB] FAIL rand_sum[%0d] a=%0d b=%0d cin=%0d sub=%0d: got %h expected %h", i, a, b, cin, sm, s, es); end
      compared++; if (c !== ec) begin mismatched++; $display("[TB] FAIL rand_carry[%0d] a=%0d b=%0d cin=%0d sub=%0d: got %b expected %b", i, a, b, cin, sm, c, ec); end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_add_example();
    test_overflow();
    test_subtract();
    test_partial();
    test_comp_stall();
    test_code_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop in case the DUT wedges somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
